pipe_stage_skid: RTL and testbench

- Generic, parametrised pipeline stage register. It replaces the per-stage hand-built banks of enable flops (decode/execute, execute/memory, and so on).
- Carries one opaque bundle of DATA_W bits using a valid/ready handshake.
- Holds a 2-entry skid buffer, so full throughput is kept while stall backpressure stays registered.
- Supports flush and nopify (bubble insertion), and keeps a saturating stall-cycle counter for performance debug.

---
 rtl/pipe_stage_skid.sv | 98 +++++++++
 tb/tb_pipe_stage_skid.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a two-entry skid buffer, a registered in_ready,
// flush and nopify controls, and a saturating stall-cycle counter.
module pipe_stage_skid #(
    parameter int                 DATA_W    = 16,
    parameter logic [DATA_W-1:0]  NOP_VALUE = '0,
    parameter int                 CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              nopify,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_count
);

    logic              m_vld_q, m_vld_d;
    logic [DATA_W-1:0] m_dat_q, m_dat_d;
    logic              s_vld_q, s_vld_d;
    logic [DATA_W-1:0] s_dat_q, s_dat_d;
    logic              in_rdy_q, in_rdy_d;
    logic [CNT_W-1:0]  stall_q, stall_d;

    logic accept, emit, store;

    assign accept = in_valid & in_rdy_q;
    assign emit   = m_vld_q & out_ready;
    // A nopified transfer completes the handshake but is never written.
    assign store  = accept & ~nopify;

    always_comb begin
        m_vld_d = m_vld_q;
        m_dat_d = m_dat_q;
        s_vld_d = s_vld_q;
        s_dat_d = s_dat_q;
        if (flush) begin
            m_vld_d = 1'b0;
            m_dat_d = NOP_VALUE;
            s_vld_d = 1'b0;
            s_dat_d = NOP_VALUE;
        end else if (!m_vld_q) begin
            // S is never occupied while M is empty.
            if (store) begin
                m_vld_d = 1'b1;
                m_dat_d = in_data;
            end
        end else if (emit) begin
            if (s_vld_q) begin
                m_dat_d = s_dat_q;
                s_vld_d = store;
                if (store) s_dat_d = in_data;
            end else begin
                m_vld_d = store;
                if (store) m_dat_d = in_data;
            end
        end else if (store) begin
            s_vld_d = 1'b1;
            s_dat_d = in_data;
        end
        in_rdy_d = ~s_vld_d;
    end

    always_comb begin
        stall_d = stall_q;
        if (m_vld_q && !out_ready && (stall_q != {CNT_W{1'b1}}))
            stall_d = stall_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_vld_q  <= 1'b0;
            m_dat_q  <= NOP_VALUE;
            s_vld_q  <= 1'b0;
            s_dat_q  <= NOP_VALUE;
            in_rdy_q <= 1'b1;
            stall_q  <= '0;
        end else begin
            m_vld_q  <= m_vld_d;
            m_dat_q  <= m_dat_d;
            s_vld_q  <= s_vld_d;
            s_dat_q  <= s_dat_d;
            in_rdy_q <= in_rdy_d;
            stall_q  <= stall_d;
        end
    end

    assign in_ready    = in_rdy_q;
    assign out_valid   = m_vld_q;
    assign out_data    = m_vld_q ? m_dat_q : NOP_VALUE;
    assign occupancy   = {1'b0, m_vld_q} + {1'b0, s_vld_q};
    assign stall_count = stall_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed scenarios plus randomized traffic
// compared against a queue-based model of the stage.
module tb_pipe_stage_skid;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = 16'h0;
    logic        nopify = 1'b0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic [1:0]  occupancy;
    logic [15:0] stall_count;

    logic        s_in_ready, s_out_valid;
    logic [15:0] s_out_data;
    logic [1:0]  s_occupancy;
    logic [2:0]  s_stall_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_stage_skid #(.DATA_W(16), .NOP_VALUE(16'h0000), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .nopify(nopify), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy), .stall_count(stall_count));

    pipe_stage_skid #(.DATA_W(16), .NOP_VALUE(16'h0000), .CNT_W(3)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_data(in_data), .nopify(nopify), .flush(flush),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
        .occupancy(s_occupancy), .stall_count(s_stall_count));

    task automatic drive(input logic iv, input logic [15:0] id, input logic nop,
                         input logic fl, input logic ordy);
        in_valid = iv; in_data = id; nopify = nop; flush = fl; out_ready = ordy;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        drive(0, 16'h0, 0, 0, 0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        drive(0, 16'h0, 0, 0, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (out_data !== 16'h0) begin errors++; $display("FAIL reset_out_data got %h exp 0000", out_data); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occupancy got %0d exp 0", occupancy); end
        checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL reset_stall got %0d exp 0", stall_count); end
        rst = 1'b1;
    endtask

    task automatic test_stream();
        logic [15:0] vals [3];
        vals[0] = 16'h1111; vals[1] = 16'h2222; vals[2] = 16'h3333;
        for (int i = 0; i < 3; i++) begin
            drive(1, vals[i], 0, 0, 1);
            tick();
            checks++; if (out_valid !== 1'b1 || out_data !== vals[i]) begin errors++; $display("FAIL stream_data[%0d] got %b/%h exp 1/%h", i, out_valid, out_data, vals[i]); end
            checks++; if (in_ready !== 1'b1 || occupancy !== 2'd1) begin errors++; $display("FAIL stream_rdy_occ[%0d] got %b/%0d exp 1/1", i, in_ready, occupancy); end
        end
        drive(0, 16'h0, 0, 0, 1);
        tick();
        checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("FAIL stream_drain got %b/%0d exp 0/0", out_valid, occupancy); end
    endtask

    task automatic test_backpressure();
        drive(1, 16'hA001, 0, 0, 0);
        tick();
        checks++; if (out_data !== 16'hA001 || occupancy !== 2'd1 || in_ready !== 1'b1 || stall_count !== 16'd0) begin errors++; $display("FAIL bp_first got %h/%0d/%b/%0d exp a001/1/1/0", out_data, occupancy, in_ready, stall_count); end
        drive(1, 16'hA002, 0, 0, 0);
        tick();
        checks++; if (out_data !== 16'hA001 || occupancy !== 2'd2 || in_ready !== 1'b0 || stall_count !== 16'd1) begin errors++; $display("FAIL bp_full got %h/%0d/%b/%0d exp a001/2/0/1", out_data, occupancy, in_ready, stall_count); end
        drive(1, 16'hA003, 0, 0, 0);
        tick();
        tick();
        checks++; if (out_data !== 16'hA001 || occupancy !== 2'd2 || in_ready !== 1'b0 || stall_count !== 16'd3) begin errors++; $display("FAIL bp_hold got %h/%0d/%b/%0d exp a001/2/0/3", out_data, occupancy, in_ready, stall_count); end
        drive(1, 16'hA003, 0, 0, 1);
        tick();
        checks++; if (out_data !== 16'hA002 || occupancy !== 2'd1 || in_ready !== 1'b1 || stall_count !== 16'd3) begin errors++; $display("FAIL bp_release1 got %h/%0d/%b/%0d exp a002/1/1/3", out_data, occupancy, in_ready, stall_count); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 16'hA003 || occupancy !== 2'd1) begin errors++; $display("FAIL bp_release2 got %b/%h/%0d exp 1/a003/1", out_valid, out_data, occupancy); end
        drive(0, 16'h0, 0, 0, 1);
        tick();
        checks++; if (out_valid !== 1'b0 || out_data !== 16'h0 || occupancy !== 2'd0 || stall_count !== 16'd3) begin errors++; $display("FAIL bp_empty got %b/%h/%0d/%0d exp 0/0000/0/3", out_valid, out_data, occupancy, stall_count); end
    endtask

    task automatic test_nopify();
        drive(1, 16'hBEEF, 1, 0, 1);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL nop_accept got %b exp 1", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0 || out_data !== 16'h0 || occupancy !== 2'd0) begin errors++; $display("FAIL nop_dropped got %b/%h/%0d exp 0/0000/0", out_valid, out_data, occupancy); end
        drive(0, 16'h0, 0, 0, 1);
    endtask

    task automatic test_flush();
        drive(1, 16'hD001, 0, 0, 0);
        tick();
        drive(1, 16'hD002, 0, 0, 0);
        tick();
        checks++; if (occupancy !== 2'd2 || stall_count !== 16'd4) begin errors++; $display("FAIL flush_setup got %0d/%0d exp 2/4", occupancy, stall_count); end
        drive(1, 16'hCAFE, 0, 1, 0);
        tick();
        checks++; if (out_valid !== 1'b0 || out_data !== 16'h0 || occupancy !== 2'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_state got %b/%h/%0d/%b exp 0/0000/0/1", out_valid, out_data, occupancy, in_ready); end
        checks++; if (stall_count !== 16'd5) begin errors++; $display("FAIL flush_keeps_stall got %0d exp 5", stall_count); end
        drive(0, 16'h0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (out_valid !== 1'b0 || out_data === 16'hCAFE) begin errors++; $display("FAIL flush_no_cafe[%0d] got %b/%h exp 0/0000", i, out_valid, out_data); end
        end
    endtask

    task automatic test_async_reset();
        pulse_reset();
        drive(1, 16'hE001, 0, 0, 0);
        tick();
        drive(1, 16'hE002, 0, 0, 0);
        tick();
        drive(0, 16'h0, 0, 0, 0);
        repeat (4) tick();
        checks++; if (occupancy !== 2'd2 || stall_count !== 16'd5) begin errors++; $display("FAIL areset_setup got %0d/%0d exp 2/5", occupancy, stall_count); end
        #2 rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_data !== 16'h0 || in_ready !== 1'b1) begin errors++; $display("FAIL areset_outputs got %b/%h/%b exp 0/0000/1", out_valid, out_data, in_ready); end
        checks++; if (occupancy !== 2'd0 || stall_count !== 16'd0) begin errors++; $display("FAIL areset_counts got %0d/%0d exp 0/0", occupancy, stall_count); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_saturation();
        drive(1, 16'hF001, 0, 0, 0);
        tick();
        drive(0, 16'h0, 0, 0, 0);
        for (int k = 1; k <= 10; k++) begin
            tick();
            checks++; if (s_stall_count !== 3'((k > 7) ? 7 : k)) begin errors++; $display("FAIL sat_count[%0d] got %0d exp %0d", k, s_stall_count, (k > 7) ? 7 : k); end
        end
        checks++; if (stall_count !== 16'd10) begin errors++; $display("FAIL sat_wide got %0d exp 10", stall_count); end
        drive(0, 16'h0, 0, 0, 1);
        repeat (2) tick();
        checks++; if (s_stall_count !== 3'd7 || s_out_valid !== 1'b0) begin errors++; $display("FAIL sat_hold got %0d/%b exp 7/0", s_stall_count, s_out_valid); end
    endtask

    task automatic test_random();
        logic [15:0] mq[$];
        int          cnt, scnt, sz;
        logic [15:0] exp_data;
        logic        acc, emt;
        pulse_reset();
        cnt = 0; scnt = 0;
        for (int c = 0; c < 600; c++) begin
            sz = mq.size();
            exp_data = (sz > 0) ? mq[0] : 16'h0;
            checks++; if (out_valid !== (sz > 0) || out_data !== exp_data) begin errors++; $display("FAIL rand_out[%0d] got %b/%h exp %b/%h", c, out_valid, out_data, sz > 0, exp_data); end
            checks++; if (in_ready !== (sz < 2) || occupancy !== 2'(sz)) begin errors++; $display("FAIL rand_rdy_occ[%0d] got %b/%0d exp %b/%0d", c, in_ready, occupancy, sz < 2, sz); end
            checks++; if (stall_count !== 16'(cnt) || s_stall_count !== 3'(scnt)) begin errors++; $display("FAIL rand_stall[%0d] got %0d/%0d exp %0d/%0d", c, stall_count, s_stall_count, cnt, scnt); end
            drive(($urandom_range(0, 9) < 7), 16'($urandom), ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 29) == 0), ($urandom_range(0, 9) < 6));
            acc = in_valid && (sz < 2);
            emt = (sz > 0) && out_ready;
            if (sz > 0 && !out_ready) begin
                if (cnt < 65535) cnt++;
                if (scnt < 7) scnt++;
            end
            if (flush) mq.delete();
            else begin
                if (emt) void'(mq.pop_front());
                if (acc && !nopify) mq.push_back(in_data);
            end
            tick();
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_stream();
        test_backpressure();
        test_nopify();
        test_flush();
        test_async_reset();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
